// File: rtl/tc_scan_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tc_scan_sched
//  Purpose  : Round-robin reader for N_CH serial thermocouple converters that
//             share one sck/so pair. Each chip gets its own active-low select.
//             Every 16-bit frame becomes a calibrated 8-bit temperature, a
//             fault flag and a channel tag.
//  Revision : 1.0 - initial release
// ============================================================================
module tc_scan_sched #(
    parameter int N_CH       = 4,
    parameter int CH_W       = 2,
    parameter int CLK_DIV    = 25000,
    parameter int CONV_WAIT  = 11000000,
    parameter int CAL_OFFSET = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic [N_CH-1:0] ch_mask,
    input  logic            so,
    output logic            sck,
    output logic [N_CH-1:0] cs_n,
    output logic [7:0]      temp_data,
    output logic [CH_W-1:0] temp_ch,
    output logic            temp_fault,
    output logic            temp_valid,
    output logic            busy
);

    localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_TMR_W = (CONV_WAIT > 0) ? $clog2(CONV_WAIT + 1) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_TMR_W-1:0] c_WAIT     = c_TMR_W'(CONV_WAIT);
    localparam logic [7:0]         c_CAL      = 8'(CAL_OFFSET);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SETUP = 3'd1;
    localparam logic [2:0] c_ST_SHIFT = 3'd2;
    localparam logic [2:0] c_ST_HOLD  = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;
    localparam logic [2:0] c_ST_GAP   = 3'd5;

    logic [2:0]         r_state;
    logic [c_DIV_W-1:0] r_cnt;
    logic [3:0]         r_bit;
    logic               r_sck;
    logic [N_CH-1:0]    r_cs_n;
    logic [15:0]        r_frame;
    logic [CH_W-1:0]    r_ch;
    logic [CH_W-1:0]    r_last;
    logic               r_busy;
    logic               r_valid;
    logic [7:0]         r_data;
    logic [CH_W-1:0]    r_tch;
    logic               r_fault;

    logic               w_div_end;
    logic               w_hold_end;
    logic [N_CH-1:0]    w_elig;
    logic               w_found;
    logic [CH_W-1:0]    w_pick;
    logic [CH_W:0]      w_cand;
    logic [7:0]         w_raw;
    logic [7:0]         w_cal;
    logic [2:0]         w_unused_bits;

    assign w_div_end     = (r_cnt == c_DIV_LAST);
    assign w_hold_end    = (r_state == c_ST_HOLD) && w_div_end;
    assign w_unused_bits = {r_frame[15], r_frame[1:0]};

    // Per-channel conversion timer: reloaded as the chip is deselected, a
    // channel is only eligible once its timer has drained to zero.
    for (genvar g = 0; g < N_CH; g++) begin : g_timer
        logic [c_TMR_W-1:0] r_tmr;

        // Count down the conversion time of this chip
        always_ff @(posedge clk) begin
            if (rst) begin
                r_tmr <= '0;
            end else if (w_hold_end && (r_ch == CH_W'(g))) begin
                r_tmr <= c_WAIT;
            end else if (r_tmr != '0) begin
                r_tmr <= r_tmr - 1'b1;
            end
        end

        assign w_elig[g] = ch_mask[g] && (r_tmr == '0);
    end

    // Round-robin scan: first eligible channel after the last one served
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int k = 1; k <= N_CH; k++) begin
            w_cand = (CH_W + 1)'(r_last) + (CH_W + 1)'(k);
            if (w_cand >= (CH_W + 1)'(N_CH)) begin
                w_cand = w_cand - (CH_W + 1)'(N_CH);
            end
            if (!w_found && w_elig[w_cand[CH_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_cand[CH_W-1:0];
            end
        end
    end

    // Calibration: subtract offset with saturation at zero, force 0 on fault
    always_comb begin
        w_raw = r_frame[14:7];
        if (r_frame[2] || (w_raw < c_CAL)) begin
            w_cal = '0;
        end else begin
            w_cal = w_raw - c_CAL;
        end
    end

    // Frame sequencer: select, clock 16 bits in, deselect, publish, rest
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_GAP;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_sck   <= 1'b0;
            r_cs_n  <= '1;
            r_frame <= '0;
            r_ch    <= '0;
            r_last  <= CH_W'(N_CH - 1);
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_tch   <= '0;
            r_fault <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (enable && w_found) begin
                        r_ch    <= w_pick;
                        r_cs_n  <= ~(N_CH'(1) << w_pick);
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= c_ST_SETUP;
                    end
                end
                c_ST_SETUP: begin
                    if (w_div_end) begin
                        // First rising sck edge captures bit 15
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_sck   <= 1'b1;
                        r_frame <= {r_frame[14:0], so};
                        r_state <= c_ST_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_SHIFT: begin
                    if (w_div_end) begin
                        r_cnt <= '0;
                        if (r_sck) begin
                            r_sck <= 1'b0;
                        end else if (r_bit == 4'd15) begin
                            r_state <= c_ST_HOLD;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_sck   <= 1'b1;
                            r_frame <= {r_frame[14:0], so};
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_HOLD: begin
                    if (w_div_end) begin
                        r_cnt   <= '0;
                        r_cs_n  <= '1;
                        r_state <= c_ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_DONE: begin
                    r_valid <= 1'b1;
                    r_tch   <= r_ch;
                    r_fault <= r_frame[2];
                    r_data  <= w_cal;
                    r_last  <= r_ch;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= c_ST_GAP;
                end
                c_ST_GAP: begin
                    if (w_div_end) begin
                        r_cnt   <= '0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= c_ST_GAP;
                end
            endcase
        end
    end

    assign sck        = r_sck;
    assign cs_n       = r_cs_n;
    assign temp_data  = r_data;
    assign temp_ch    = r_tch;
    assign temp_fault = r_fault;
    assign temp_valid = r_valid;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_tc_scan_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tc_scan_sched
//  Purpose  : Self-checking bench for tc_scan_sched. A frame-level timeline
//             model predicts every output each cycle; directed scenarios pin
//             hand-computed values, then a randomized run follows.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tc_scan_sched;

    localparam int N   = 4;
    localparam int W   = 2;
    localparam int D   = 2;
    localparam int CW  = 200;
    localparam int OFF = 5;
    localparam int FR  = 34 * D;

    logic         clk     = 1'b0;
    logic         rst     = 1'b1;
    logic         enable  = 1'b0;
    logic [N-1:0] ch_mask = '0;
    logic         so      = 1'b0;
    logic         sck;
    logic [N-1:0] cs_n;
    logic [7:0]   temp_data;
    logic [W-1:0] temp_ch;
    logic         temp_fault;
    logic         temp_valid;
    logic         busy;

    tc_scan_sched #(
        .N_CH      (N),
        .CH_W      (W),
        .CLK_DIV   (D),
        .CONV_WAIT (CW),
        .CAL_OFFSET(OFF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .ch_mask   (ch_mask),
        .so        (so),
        .sck       (sck),
        .cs_n      (cs_n),
        .temp_data (temp_data),
        .temp_ch   (temp_ch),
        .temp_fault(temp_fault),
        .temp_valid(temp_valid),
        .busy      (busy)
    );

    // Free-running clock
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- chip models ----------------
    logic [15:0] chip_frame [N];
    bit          rand_frames = 1'b0;

    logic [15:0]  drv_frame = '0;
    int           rises     = 0;
    logic         p_sck     = 1'b0;
    logic [N-1:0] p_cs      = '1;

    // Selected chip presents bit (15 - rising edges seen) on so
    always @(negedge clk) begin
        if (cs_n != '1 && p_cs == '1) begin
            for (int i = 0; i < N; i++) begin
                if (!cs_n[i]) drv_frame = chip_frame[i];
            end
            rises = 0;
        end else if (sck && !p_sck) begin
            rises++;
        end
        p_sck = sck;
        p_cs  = cs_n;
        so    = (rises < 16) ? drv_frame[15 - rises] : 1'b0;
    end

    // ---------------- behavioural model ----------------
    int          cyc = 0;
    bit          m_on = 1'b0;
    bit          m_in = 1'b0;
    int          m_t0 = 0;
    int          m_ch = 0;
    int          m_idle = 0;
    int          m_last = N - 1;
    int          m_ready [N];
    logic [15:0] m_frame = '0;
    int          m_valid_at = -1;
    int          m_data = 0;
    int          m_tch = 0;
    int          m_fault = 0;

    function automatic int cal(input logic [15:0] f);
        int raw;
        raw = int'(f[14:7]);
        if (f[2]) return 0;
        return (raw < OFF) ? 0 : raw - OFF;
    endfunction

    // Timeline model: a frame starting in cycle t0 occupies the bus for 34*D
    // cycles, publishes one cycle after deselect, then rests D cycles.
    always @(posedge clk) begin
        int c;
        if (rst) begin
            m_on       = 1'b1;
            m_in       = 1'b0;
            m_idle     = cyc + 1 + D;
            m_last     = N - 1;
            m_valid_at = -1;
            m_data     = 0;
            m_tch      = 0;
            m_fault    = 0;
            for (int i = 0; i < N; i++) m_ready[i] = 0;
        end else if (m_on) begin
            if (m_in && cyc == m_t0 + FR) begin
                m_in       = 1'b0;
                m_valid_at = cyc + 1;
                m_data     = cal(m_frame);
                m_tch      = m_ch;
                m_fault    = int'(m_frame[2]);
                m_last     = m_ch;
                m_idle     = cyc + 1 + D;
                if (rand_frames) chip_frame[m_ch] = 16'($urandom);
            end else if (!m_in && cyc >= m_idle && enable) begin
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (!m_in && ch_mask[c] && cyc >= m_ready[c]) begin
                        m_in       = 1'b1;
                        m_t0       = cyc + 1;
                        m_ch       = c;
                        m_ready[c] = m_t0 + FR + CW;
                        m_frame    = chip_frame[c];
                    end
                end
            end
        end
        cyc++;
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        int           off;
        logic [N-1:0] e_cs;
        logic         e_sck;
        if (m_on) begin
            off   = cyc - m_t0;
            e_cs  = '1;
            e_sck = 1'b0;
            if (m_in && off < FR) begin
                e_cs[m_ch] = 1'b0;
                if (off >= D && off < 33 * D && ((off - D) / D) % 2 == 0) e_sck = 1'b1;
            end
            chk("cs_n", int'(cs_n), int'(e_cs));
            chk("sck", int'(sck), int'(e_sck));
            chk("busy", int'(busy), int'(m_in));
            chk("temp_valid", int'(temp_valid), int'(cyc == m_valid_at));
            chk("temp_data", int'(temp_data), m_data);
            chk("temp_ch", int'(temp_ch), m_tch);
            chk("temp_fault", int'(temp_fault), m_fault);
            chk("one_cs_low", int'($countones(~cs_n) <= 1), 1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int budget, input string name, output int ch);
        bit got;
        got = 1'b0;
        ch  = -1;
        for (int k = 0; k < budget && !got; k++) begin
            tick();
            if (temp_valid) begin
                got = 1'b1;
                ch  = int'(temp_ch);
            end
        end
        chk({name, "_seen"}, int'(got), 1);
    endtask

    task automatic wait_cs_fall(input int budget, input string name);
        bit got;
        got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            tick();
            if (cs_n != '1) got = 1'b1;
        end
        chk({name, "_seen"}, int'(got), 1);
    endtask

    // ---------------- directed and random scenarios ----------------
    initial begin
        int           ch;
        int           low;
        int           pul;
        int           nstb;
        int           nf0;
        int           f0 [2];
        int           r0;
        int           falls;
        int           cnt;
        bit           got;
        logic         psck;
        logic [N-1:0] pcs;
        int           exp_order [6];

        exp_order = '{0, 1, 3, 0, 1, 3};
        for (int i = 0; i < N; i++) chip_frame[i] = '0;

        // Reset values
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_cs_n", int'(cs_n), 15);
        chk("rst_sck", int'(sck), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(temp_valid), 0);
        chk("rst_data", int'(temp_data), 0);

        // Single frame 0x0C80 on ch0: raw 25 -> 20
        ch_mask       = 4'b0001;
        enable        = 1'b1;
        chip_frame[0] = 16'h0C80;
        rst           = 1'b0;
        low = 0; pul = 0; got = 1'b0; psck = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
            tick();
            if (!cs_n[0]) low++;
            if (sck && !psck) pul++;
            psck = sck;
            if (temp_valid) got = 1'b1;
        end
        chk("t1_valid_seen", int'(got), 1);
        chk("t1_cs_low_cycles", low, 68);
        chk("t1_sck_pulses", pul, 16);
        chk("t1_data", int'(temp_data), 20);
        chk("t1_ch", int'(temp_ch), 0);
        chk("t1_fault", int'(temp_fault), 0);
        chk("t1_model_data", m_data, 20);

        // Round robin over mask 1011 with conversion wait on ch0
        rand_frames = 1'b1;
        ch_mask     = 4'b1011;
        do_reset();
        nstb = 0; nf0 = 0; r0 = -1; pcs = cs_n;
        f0[0] = 0; f0[1] = 0;
        for (int k = 0; k < 1500 && nstb < 6; k++) begin
            tick();
            if (pcs[0] && !cs_n[0]) begin
                if (nf0 < 2) f0[nf0] = cyc;
                nf0++;
            end
            if (!pcs[0] && cs_n[0] && r0 < 0) r0 = cyc;
            pcs = cs_n;
            if (temp_valid) begin
                chk($sformatf("t2_order%0d", nstb), int'(temp_ch), exp_order[nstb]);
                nstb++;
            end
        end
        chk("t2_strobes", nstb, 6);
        chk("t2_ch0_wait_ok", int'(nf0 >= 2 && r0 >= 0 && (f0[1] - r0) >= CW), 1);

        // Saturation and fault decoding (bits 15,1,0 set but ignored)
        rand_frames   = 1'b0;
        ch_mask       = 4'b0001;
        chip_frame[0] = 16'h8183;
        do_reset();
        wait_valid(300, "t3a", ch);
        chk("t3a_data", int'(temp_data), 0);
        chk("t3a_fault", int'(temp_fault), 0);
        chip_frame[0] = 16'h3204;
        wait_valid(400, "t3b", ch);
        chk("t3b_data", int'(temp_data), 0);
        chk("t3b_fault", int'(temp_fault), 1);

        // Enable dropped while ch1 shifts
        rand_frames = 1'b1;
        ch_mask     = 4'b1111;
        do_reset();
        got = 1'b0;
        for (int k = 0; k < 300 && !got; k++) begin
            tick();
            if (!cs_n[1]) got = 1'b1;
        end
        chk("t4_ch1_sel_seen", int'(got), 1);
        repeat (2 * D + 3) tick();
        enable = 1'b0;
        wait_valid(200, "t4a", ch);
        chk("t4a_ch", ch, 1);
        falls = 0; pcs = cs_n;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (pcs == '1 && cs_n != '1) falls++;
            pcs = cs_n;
        end
        chk("t4_no_falls_disabled", falls, 0);
        enable = 1'b1;
        wait_valid(300, "t4b", ch);
        chk("t4b_ch", ch, 2);

        // Reset in the middle of bit 8
        do_reset();
        wait_cs_fall(300, "t5_start");
        repeat (D + 2 * D * 8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_cs_n", int'(cs_n), 15);
        chk("t5_sck", int'(sck), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_valid", int'(temp_valid), 0);
        cnt = 0; got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            tick();
            cnt++;
            if (cs_n != '1) got = 1'b1;
        end
        chk("t5_restart_delay", cnt, D + 1);
        chk("t5_restart_sel", int'(cs_n), 14);
        wait_valid(200, "t5", ch);
        chk("t5_ch", ch, 0);

        // Empty mask keeps the bus quiet
        ch_mask = '0;
        do_reset();
        low = 0; cnt = 0; nstb = 0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (cs_n != '1) low++;
            if (busy) cnt++;
            if (temp_valid) nstb++;
        end
        chk("t6_cs_low", low, 0);
        chk("t6_busy", cnt, 0);
        chk("t6_valid", nstb, 0);

        // Randomized run against the model
        ch_mask = 4'b1111;
        enable  = 1'b1;
        for (int k = 0; k < 15000; k++) begin
            tick();
            if ($urandom_range(149, 0) == 0) enable = ~enable;
            if ($urandom_range(199, 0) == 0) ch_mask = N'($urandom);
            rst = ($urandom_range(2499, 0) == 0);
        end
        rst = 1'b0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
